// File: rtl/sr_latch_bank_pkg.sv
// Shared constants and next-state rule for the set/reset storage bank.
package sr_pkg;

  localparam int MODE_RST_DOM = 0;
  localparam int MODE_SET_DOM = 1;
  localparam int MODE_HOLD    = 2;
  localparam int MODE_TOGGLE  = 3;

  // Next value of one cell given its current state, the set/reset pair and
  // the s=r=1 resolution mode.
  function automatic logic next_q(input logic q, input logic s, input logic r, input int mode);
    logic res;
    res = q;
    case ({s, r})
      2'b10:   res = 1'b1;
      2'b01:   res = 1'b0;
      2'b11: begin
        case (mode)
          MODE_RST_DOM: res = 1'b0;
          MODE_SET_DOM: res = 1'b1;
          MODE_HOLD:    res = q;
          default:      res = ~q;
        endcase
      end
      default: res = q;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sr_latch_bank_cell.sv
// One storage channel: optional s/r synchroniser, state flop and sticky
// conflict bit, plus a one-cycle conflict-event strobe for the bank counter.
module sr_cell
  import sr_pkg::*;
#(
  parameter int MODE        = MODE_RST_DOM,
  parameter int SYNC_STAGES = 0,
  parameter bit RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic s,
  input  logic r,
  input  logic clr_err,
  output logic q,
  output logic conflict,
  output logic conflict_evt
);

  logic ss;
  logic rs;

  if (MODE < 0 || MODE > 3) begin : g_bad_mode
    $error("sr_cell: MODE must be 0..3");
  end
  if (SYNC_STAGES < 0 || SYNC_STAGES > 2) begin : g_bad_sync
    $error("sr_cell: SYNC_STAGES must be 0, 1 or 2");
  end

  if (SYNC_STAGES > 0) begin : g_sync
    logic [SYNC_STAGES-1:0] s_pipe;
    logic [SYNC_STAGES-1:0] r_pipe;

    // Shift the raw requests through the synchroniser; reset flushes them idle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s_pipe <= '0;
        r_pipe <= '0;
      end else begin
        s_pipe[0] <= s;
        r_pipe[0] <= r;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          s_pipe[i] <= s_pipe[i-1];
          r_pipe[i] <= r_pipe[i-1];
        end
      end
    end

    assign ss = s_pipe[SYNC_STAGES-1];
    assign rs = r_pipe[SYNC_STAGES-1];
  end else begin : g_nosync
    assign ss = s;
    assign rs = r;
  end

  assign conflict_evt = en & ss & rs;

  // State flop: only moves when enabled, using the shared resolution rule.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= next_q(q, ss, rs, MODE);
    end
  end

  // Sticky conflict bit; a new event beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict <= 1'b0;
    end else if (conflict_evt) begin
      conflict <= 1'b1;
    end else if (clr_err) begin
      conflict <= 1'b0;
    end
  end

endmodule

// File: rtl/sr_latch_bank.sv
// Bank of WIDTH independent set/reset cells with a shared saturating
// conflict counter (one count per edge with any conflicting channel).
module sr_latch_bank
  import sr_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int MODE        = MODE_RST_DOM,
  parameter int SYNC_STAGES = 0,
  parameter bit RST_VAL     = 1'b0,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] conflict,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] conflict_evt;
  logic             any_evt;

  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("sr_latch_bank: WIDTH must be 1..64");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("sr_latch_bank: CNT_W must be at least 1");
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    sr_cell #(
      .MODE        (MODE),
      .SYNC_STAGES (SYNC_STAGES),
      .RST_VAL     (RST_VAL)
    ) u_cell (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .s            (s[gi]),
      .r            (r[gi]),
      .clr_err      (clr_err),
      .q            (q[gi]),
      .conflict     (conflict[gi]),
      .conflict_evt (conflict_evt[gi])
    );
  end

  assign any_evt = |conflict_evt;
  assign qbar    = ~q;

  // Saturating event counter; an event on a clearing edge restarts it at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if (any_evt) begin
      if (clr_err) begin
        conflict_cnt <= CNT_W'(1);
      end else if (conflict_cnt != CNT_MAX) begin
        conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
    end else if (clr_err) begin
      conflict_cnt <= '0;
    end
  end

endmodule
